// File: rtl/seg7_scan_display.sv
// ---------------------------------------------------------------------------
// seg7_scan_display
//   Multi-digit 7-segment display driver. A binary value captured on load_i
//   is converted to hex nibbles (one cycle) or unsigned decimal BCD
//   (sequential double-dabble, one bit per cycle), then committed atomically
//   to the display register. DIGITS digits share one segment bus and are lit
//   one at a time, each for REFRESH_DIV clock cycles.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   load_i      1-cycle strobe: capture data_i / hex_mode_i, start conversion
//   data_i      binary value to display (DATA_W bits)
//   hex_mode_i  1: hexadecimal, 0: unsigned decimal
//   blank_lz_i  1: blank leading zeros (digit 0 never blanked), live input
//   busy_o      conversion in progress; load_i ignored while high
//   ovf_o       last loaded value does not fit in DIGITS digits
//   seg_o       segments {g,f,e,d,c,b,a}, registered
//   dig_o       digit enables, bit i = digit i, registered
// ---------------------------------------------------------------------------
module seg7_scan_display #(
  parameter int DATA_W         = 16,
  parameter int DIGITS         = 5,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              hex_mode_i,
  input  logic              blank_lz_i,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [6:0]        seg_o,
  output logic [DIGITS-1:0] dig_o
);

  // Decimal digits needed for a DATA_W-bit value: floor(0.3*W)+1 matches
  // floor(W*log10(2))+1 for every width in 4..32.
  localparam int DEC_DIGITS = (DATA_W * 3) / 10 + 1;
  localparam int BCD_N      = (DEC_DIGITS > DIGITS) ? DEC_DIGITS : DIGITS;
  localparam int BCD_W      = 4 * BCD_N;
  localparam int DISP_W     = 4 * DIGITS;
  localparam int CNT_W      = $clog2(DATA_W);
  localparam int RC_W       = $clog2(REFRESH_DIV);
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONV   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               hex_q;
  logic [DATA_W-1:0]  bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               spill_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DISP_W-1:0]  disp_q;
  logic               ovf_q;
  logic [RC_W-1:0]    refresh_q;
  logic [IDX_W-1:0]   idx_q;
  logic [6:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  dig_q, dig_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [DISP_W-1:0]  hex_nib;
  logic               hex_ovf;
  logic               dec_ovf;
  logic [DIGITS-1:0]  blank_vec;
  logic               last_bit;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (load_i) state_d = S_CONV;
      S_CONV:   if (hex_q || last_bit) state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // Conversion datapath
  // -------------------------------------------------------------------------
  // Double-dabble add-3 on every BCD nibble >= 5 before the shift.
  for (genvar gi = 0; gi < BCD_N; gi++) begin : g_add3
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
  end

  if (DATA_W >= DISP_W) begin : g_hex_wide
    assign hex_nib = bin_q[DISP_W-1:0];
  end else begin : g_hex_narrow
    assign hex_nib = DISP_W'(bin_q);
  end

  if (DATA_W > DISP_W) begin : g_hex_ovf
    assign hex_ovf = |bin_q[DATA_W-1:DISP_W];
  end else begin : g_hex_noovf
    assign hex_ovf = 1'b0;
  end

  // spill_q catches a bit shifted out of the BCD register; with the digit
  // count sized above it stays clear, but it keeps the overflow flag honest.
  if (BCD_N > DIGITS) begin : g_dec_ovf
    assign dec_ovf = spill_q | (|bcd_q[BCD_W-1:DISP_W]);
  end else begin : g_dec_noovf
    assign dec_ovf = spill_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      spill_q <= 1'b0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_i) begin
            hex_q   <= hex_mode_i;
            bin_q   <= data_i;
            bcd_q   <= '0;
            spill_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_CONV: begin
          if (!hex_q) begin
            bcd_q   <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
            spill_q <= spill_q | bcd_adj[BCD_W-1];
            bin_q   <= {bin_q[DATA_W-2:0], 1'b0};
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        S_UPDATE: begin
          disp_q <= hex_q ? hex_nib : bcd_q[DISP_W-1:0];
          ovf_q  <= hex_q ? hex_ovf : dec_ovf;
        end
        default: ;
      endcase
    end
  end

  assign ovf_o = ovf_q;

  // -------------------------------------------------------------------------
  // Scan and decode
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == RC_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      refresh_q <= refresh_q + RC_W'(1);
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_lsd
      assign blank_vec[gi] = 1'b0;
    end else begin : g_upper
      assign blank_vec[gi] = blank_lz_i & ~ovf_q & (disp_q[DISP_W-1:4*gi] == '0);
    end
  end

  function automatic logic [6:0] nib_to_seg(input logic [3:0] n);
    case (n)
      4'h0: nib_to_seg = 7'h3F;
      4'h1: nib_to_seg = 7'h06;
      4'h2: nib_to_seg = 7'h5B;
      4'h3: nib_to_seg = 7'h4F;
      4'h4: nib_to_seg = 7'h66;
      4'h5: nib_to_seg = 7'h6D;
      4'h6: nib_to_seg = 7'h7D;
      4'h7: nib_to_seg = 7'h07;
      4'h8: nib_to_seg = 7'h7F;
      4'h9: nib_to_seg = 7'h6F;
      4'hA: nib_to_seg = 7'h77;
      4'hB: nib_to_seg = 7'h7C;
      4'hC: nib_to_seg = 7'h39;
      4'hD: nib_to_seg = 7'h5E;
      4'hE: nib_to_seg = 7'h79;
      default: nib_to_seg = 7'h71;
    endcase
  endfunction

  always_comb begin
    logic [6:0] code;
    if (ovf_q) begin
      code = 7'h40;
    end else if (blank_vec[idx_q]) begin
      code = 7'h00;
    end else begin
      code = nib_to_seg(disp_q[{idx_q, 2'b00} +: 4]);
    end
    seg_d = code ^ {7{SEG_ACTIVE_LOW}};
    dig_d = (DIGITS'(1) << idx_q) ^ {DIGITS{DIG_ACTIVE_LOW}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= {7{SEG_ACTIVE_LOW}};
      dig_q <= {DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  end

  assign seg_o = seg_q;
  assign dig_o = dig_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_display
//   Drives a 5-digit and a 3-digit instance (16-bit data, REFRESH_DIV=4,
//   active-low) from the same stimulus. Expected segments come from a
//   division/modulo model of the displayed value.
// ---------------------------------------------------------------------------
module tb_seg7_scan_display;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data;
  logic        hex_mode;
  logic        blank_lz;
  logic        busy5, ovf5, busy3, ovf3;
  logic [6:0]  seg5, seg3;
  logic [4:0]  dig5;
  logic [2:0]  dig3;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [16];

  typedef struct packed {
    logic        hx;
    logic        blz;
    logic [15:0] data;
    logic [34:0] segs;   // {digit4,...,digit0}, active-low
    logic [7:0]  busy;
  } vec_t;

  vec_t vecs [7];

  seg7_scan_display #(
    .DATA_W(16), .DIGITS(5), .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load), .data_i(data),
    .hex_mode_i(hex_mode), .blank_lz_i(blank_lz),
    .busy_o(busy5), .ovf_o(ovf5), .seg_o(seg5), .dig_o(dig5)
  );

  seg7_scan_display #(
    .DATA_W(16), .DIGITS(3), .REFRESH_DIV(4),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .load_i(load), .data_i(data),
    .hex_mode_i(hex_mode), .blank_lz_i(blank_lz),
    .busy_o(busy3), .ovf_o(ovf3), .seg_o(seg3), .dig_o(dig3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: value -> active-low segment pattern of digit i.
  function automatic logic [6:0] exp_seg(input int ndig, input bit hx, input bit blz,
                                         input longint v, input int i);
    longint base, pw, lim, d;
    base = hx ? 16 : 10;
    pw = 1;
    lim = 1;
    for (int k = 0; k < i; k++) pw *= base;
    for (int k = 0; k < ndig; k++) lim *= base;
    if (v >= lim) return 7'h3F;
    if (i > 0 && blz && v < pw) return 7'h7F;
    d = (v / pw) % base;
    return ~seg_tab[int'(d)];
  endfunction

  function automatic bit exp_ovf(input int ndig, input bit hx, input longint v);
    longint lim;
    lim = 1;
    for (int k = 0; k < ndig; k++) lim *= (hx ? 16 : 10);
    return v >= lim;
  endfunction

  task automatic start_load(input bit hx, input logic [15:0] v);
    @(negedge clk);
    load = 1'b1;
    hex_mode = hx;
    data = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Counts busy cycles, starting from the negedge right after the load edge.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy5 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 100) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy after %0d cycles required idle", cycles);
    end
  endtask

  task automatic read_seg(input bit three, input int i, output logic [6:0] s);
    logic [7:0] target, cur;
    bit found;
    found = 1'b0;
    cur = '0;
    s = 'x;
    target = three ? (8'h07 & ~(8'd1 << i)) : (8'h1F & ~(8'd1 << i));
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      cur = three ? {5'd0, dig3} : {3'd0, dig5};
      if (cur == target) begin
        found = 1'b1;
        s = three ? seg3 : seg5;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL scan_reach d%0d i%0d: got dig %0h required %0h", three ? 3 : 5, i, cur, target);
    end
  endtask

  task automatic check_display(input longint v, input bit hx, input bit blz);
    logic [6:0] s;
    for (int sel = 0; sel < 2; sel++) begin
      int nd;
      nd = (sel == 1) ? 3 : 5;
      for (int i = 0; i < nd; i++) begin
        read_seg(sel == 1, i, s);
        check($sformatf("seg_d%0d_i%0d_v%0h", nd, i, v), {25'd0, s}, {25'd0, exp_seg(nd, hx, blz, v, i)});
      end
    end
  endtask

  initial begin
    logic [4:0] dseq [5];
    logic [6:0] s;
    int n;
    bit hx, blz;
    logic [15:0] v;

    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    dseq = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F};

    vecs[0] = '{1'b0, 1'b0, 16'hFFFF, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}, 8'd17};
    vecs[1] = '{1'b1, 1'b1, 16'hBEEF, {7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E}, 8'd2};
    vecs[2] = '{1'b1, 1'b1, 16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'd2};
    vecs[3] = '{1'b0, 1'b0, 16'd123,  {7'h40, 7'h40, 7'h79, 7'h24, 7'h30}, 8'd17};
    vecs[4] = '{1'b0, 1'b1, 16'd123,  {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30}, 8'd17};
    vecs[5] = '{1'b1, 1'b0, 16'h1234, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19}, 8'd2};
    vecs[6] = '{1'b0, 1'b1, 16'd10,   {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40}, 8'd17};

    // ---------------- reset and scan order ----------------
    rst_n = 1'b0;
    load = 1'b0;
    data = '0;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_seg", {25'd0, seg5}, 32'h7F);
    check("rst_dig", {27'd0, dig5}, 32'h1F);
    check("rst_dig3", {29'd0, dig3}, 32'h7);
    check("rst_busy", {31'd0, busy5}, 32'h0);
    check("rst_ovf3", {31'd0, ovf3}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_seg", {25'd0, seg5}, 32'h40);
    for (int j = 0; j < 6; j++) begin
      check($sformatf("scan_dig_%0d", j), {27'd0, dig5}, {27'd0, dseq[j % 5]});
      repeat (4) @(negedge clk);
    end
    $display("reset/scan sequence checked");

    // ---------------- table-driven loads ----------------
    for (int t = 0; t < 7; t++) begin
      blank_lz = vecs[t].blz;
      start_load(vecs[t].hx, vecs[t].data);
      wait_idle(n);
      check($sformatf("vec%0d_busy", t), n, {24'd0, vecs[t].busy});
      check($sformatf("vec%0d_ovf", t), {31'd0, ovf5}, 32'h0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        read_seg(1'b0, i, s);
        check($sformatf("vec%0d_seg_i%0d", t, i), {25'd0, s}, {25'd0, vecs[t].segs[7*i +: 7]});
      end
      $display("vec %0d: hex=%0d blz=%0d data=%h busy=%0d", t, vecs[t].hx, vecs[t].blz, vecs[t].data, n);
    end

    // ---------------- hex latency and decimal overflow on 3 digits ----------------
    blank_lz = 1'b0;
    start_load(1'b0, 16'd5);
    wait_idle(n);
    start_load(1'b1, 16'hBEEF);
    check("hexlat_e0_ovf3", {31'd0, ovf3}, 32'h0);
    @(negedge clk);
    check("hexlat_e1_ovf3", {31'd0, ovf3}, 32'h0);
    check("hexlat_e1_busy", {31'd0, busy5}, 32'h1);
    @(negedge clk);
    check("hexlat_e2_ovf3", {31'd0, ovf3}, 32'h1);
    check("hexlat_e2_busy", {31'd0, busy5}, 32'h0);
    $display("hex latency: load BEEF, ovf3 rises 2 cycles after load");

    start_load(1'b0, 16'd5);
    wait_idle(n);
    start_load(1'b0, 16'd1000);
    repeat (16) @(negedge clk);
    check("dec_last_busy", {31'd0, busy5}, 32'h1);
    check("dec_last_ovf3", {31'd0, ovf3}, 32'h0);
    @(negedge clk);
    check("dec_done_busy", {31'd0, busy5}, 32'h0);
    check("dec_done_ovf3", {31'd0, ovf3}, 32'h1);
    check("dec_done_ovf5", {31'd0, ovf5}, 32'h0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      read_seg(1'b1, i, s);
      check($sformatf("ovf3_dash_i%0d", i), {25'd0, s}, 32'h3F);
    end
    check_display(1000, 1'b0, 1'b0);
    $display("overflow: dec 1000 on 3 digits shows dashes");

    // ---------------- abort by reset mid-conversion ----------------
    start_load(1'b0, 16'd999);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy5}, 32'h0);
    check("abort_busy3", {31'd0, busy3}, 32'h0);
    check("abort_ovf3", {31'd0, ovf3}, 32'h0);
    check("abort_seg", {25'd0, seg5}, 32'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    check_display(0, 1'b0, 1'b0);
    $display("abort: reset mid-conversion clears display");

    // ---------------- reload while busy is dropped ----------------
    start_load(1'b0, 16'd123);
    repeat (4) @(negedge clk);
    load = 1'b1;
    hex_mode = 1'b1;
    data = 16'd999;
    @(negedge clk);
    load = 1'b0;
    wait_idle(n);
    check("reload_busy_rest", n, 32'd12);
    repeat (2) @(negedge clk);
    check_display(123, 1'b0, 1'b0);
    $display("reload: second load during busy ignored, display 00123");

    // ---------------- randomized loads vs model ----------------
    for (int r = 0; r < 12; r++) begin
      hx = 1'($urandom_range(0, 1));
      blz = 1'($urandom_range(0, 1));
      v = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      blank_lz = blz;
      start_load(hx, v);
      wait_idle(n);
      check($sformatf("rnd%0d_busy", r), n, hx ? 32'd2 : 32'd17);
      repeat (2) @(negedge clk);
      check($sformatf("rnd%0d_ovf5", r), {31'd0, ovf5}, {31'd0, exp_ovf(5, hx, v)});
      check($sformatf("rnd%0d_ovf3", r), {31'd0, ovf3}, {31'd0, exp_ovf(3, hx, v)});
      check_display(v, hx, blz);
      $display("rnd %0d: hex=%0d blz=%0d data=%h", r, hx, blz, v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
